// File: rtl/rv_alu_core.sv
// rv_alu_core: multicycle RV32I ALU-subset core.
// FETCH -> REGS -> EXEC per instruction; SYSTEM opcodes halt.
module rv_alu_core #(
  parameter int          PC_W     = 6,
  parameter int unsigned RESET_PC = 0,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             resetn,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [31:0]      wb_data,
  output logic [CNT_W-1:0] instret,
  output logic             halted,
  output logic [3:0]       state_oh
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_REGS,
    S_EXEC,
    S_HALT
  } state_t;

  state_t state;
  state_t state_nx;

  logic [PC_W-1:0] pc;
  logic [31:0]     instr;
  logic [31:0]     rs1;
  logic [31:0]     rs2;
  logic [31:0]     rf [32];

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        is_r;
  logic        is_i;
  logic        is_sys;
  logic        is_alu;
  logic        rf_we;
  logic [31:0] op2;
  logic [4:0]  shamt;
  logic [31:0] alu_res;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign rd     = instr[11:7];
  assign is_r   = (opcode == 7'b0110011);
  assign is_i   = (opcode == 7'b0010011);
  assign is_sys = (opcode == 7'b1110011);
  assign is_alu = is_r | is_i;
  assign op2    = is_r ? rs2 : {{20{instr[31]}}, instr[31:20]};
  assign shamt  = op2[4:0];

  assign imem_req  = (state == S_FETCH);
  assign imem_addr = pc;

  // Reset low on the edge suppresses the write: aborted ops leave no trace.
  assign rf_we = resetn && (state == S_EXEC) && is_alu && (rd != 5'd0);

  always_comb begin
    alu_res = '0;
    unique case (funct3)
      3'b000: alu_res = (is_r && instr[30]) ? rs1 - op2 : rs1 + op2;
      3'b001: alu_res = rs1 << shamt;
      3'b010: alu_res = {31'd0, $signed(rs1) < $signed(op2)};
      3'b011: alu_res = {31'd0, rs1 < op2};
      3'b100: alu_res = rs1 ^ op2;
      3'b101: alu_res = instr[30] ? $unsigned($signed(rs1) >>> shamt)
                                  : rs1 >> shamt;
      3'b110: alu_res = rs1 | op2;
      3'b111: alu_res = rs1 & op2;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_FETCH: if (imem_ack) state_nx = S_REGS;
      S_REGS:  state_nx = S_EXEC;
      S_EXEC:  state_nx = is_sys ? S_HALT : S_FETCH;
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_FETCH;
    endcase
  end

  always_comb begin
    state_oh = 4'b0000;
    unique case (state)
      S_FETCH: state_oh = 4'b0001;
      S_REGS:  state_oh = 4'b0010;
      S_EXEC:  state_oh = 4'b0100;
      S_HALT:  state_oh = 4'b1000;
      default: state_oh = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_FETCH;
      pc       <= PC_W'(RESET_PC);
      instr    <= '0;
      instret  <= '0;
      halted   <= 1'b0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      state    <= state_nx;
      wb_valid <= 1'b0;
      if (state == S_FETCH && imem_ack) begin
        instr <= imem_rdata;
      end
      if (state == S_EXEC) begin
        instret <= instret + CNT_W'(1);
        if (is_sys) begin
          halted <= 1'b1;
        end else begin
          pc <= pc + PC_W'(1);
        end
        if (is_alu && rd != 5'd0) begin
          wb_valid <= 1'b1;
          wb_rd    <= rd;
          wb_data  <= alu_res;
        end
      end
    end
  end

  // Register bank has no reset; x0 is forced to zero on read.
  always_ff @(posedge clk) begin
    if (state == S_REGS) begin
      rs1 <= (instr[19:15] == 5'd0) ? 32'd0 : rf[instr[19:15]];
      rs2 <= (instr[24:20] == 5'd0) ? 32'd0 : rf[instr[24:20]];
    end
    if (rf_we) begin
      rf[rd] <= alu_res;
    end
  end

endmodule

// File: tb/tb_rv_alu_core.sv
// tb_rv_alu_core: random and directed programs against an
// architectural model of the ALU subset.
module tb_rv_alu_core;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [5:0]  imem_addr;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [15:0] instret;
  logic        halted;
  logic [3:0]  state_oh;

  logic        ack2 = 1'b0;
  logic [31:0] rdata2 = '0;
  logic        req2;
  logic [1:0]  addr2;
  logic        wbv2;
  logic [4:0]  wbrd2;
  logic [31:0] wbd2;
  logic [15:0] inst2;
  logic        halt2;
  logic [3:0]  so2;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] mx [32];
  int unsigned mpc = 0;
  int unsigned mret = 0;
  logic        mhalt = 1'b0;
  logic [31:0] last_wb = '0;

  rv_alu_core u_dut (
    .clk(clk), .resetn(resetn),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .instret(instret), .halted(halted), .state_oh(state_oh)
  );

  rv_alu_core #(.PC_W(2), .RESET_PC(3), .CNT_W(16)) u_small (
    .clk(clk), .resetn(resetn),
    .imem_req(req2), .imem_addr(addr2),
    .imem_ack(ack2), .imem_rdata(rdata2),
    .wb_valid(wbv2), .wb_rd(wbrd2), .wb_data(wbd2),
    .instret(inst2), .halted(halt2), .state_oh(so2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [31:0] ins);
    logic [31:0] a;
    logic [31:0] b;
    int sh;
    bit r;
    r = (ins[6:0] == 7'b0110011);
    a = mx[ins[19:15]];
    b = r ? mx[ins[24:20]] : {{20{ins[31]}}, ins[31:20]};
    sh = int'(b[4:0]);
    case (ins[14:12])
      3'd0: return (r && ins[30]) ? a - b : a + b;
      3'd1: return a * (32'd1 << sh);
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: begin
        if (ins[30] && a[31])
          return (a >> sh) | ~(32'hFFFF_FFFF >> sh);
        return a >> sh;
      end
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic run(input logic [31:0] ins, input int waits);
    bit got;
    bit wr;
    logic [6:0] opc;
    logic [31:0] res;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      if (imem_req) got = 1'b1;
      else @(negedge clk);
    end
    chk("req_seen", 32'(got), 32'd1);
    chk("fetch_addr", 32'(imem_addr), mpc);
    for (int w = 0; w < waits; w++) begin
      imem_ack = 1'b0;
      imem_rdata = $urandom;
      @(negedge clk);
      chk("wait_addr", 32'(imem_addr), mpc);
    end
    imem_ack = 1'b1;
    imem_rdata = ins;
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    chk("st_regs", 32'(state_oh), 32'd2);
    @(negedge clk);
    chk("st_exec", 32'(state_oh), 32'd4);
    @(negedge clk);
    opc = ins[6:0];
    wr = 1'b0;
    res = '0;
    mret = (mret + 1) % 65536;
    if (opc == 7'b0110011 || opc == 7'b0010011) begin
      res = ref_alu(ins);
      wr = (ins[11:7] != 5'd0);
      if (wr) mx[ins[11:7]] = res;
      mpc = (mpc + 1) % 64;
    end else if (opc == 7'b1110011) begin
      mhalt = 1'b1;
    end else begin
      mpc = (mpc + 1) % 64;
    end
    chk("wb_valid", 32'(wb_valid), 32'(wr));
    if (wr) begin
      chk("wb_rd", 32'(wb_rd), 32'(ins[11:7]));
      chk("wb_data", wb_data, res);
      last_wb = wb_data;
    end
    chk("instret", 32'(instret), mret);
    chk("halted", 32'(halted), 32'(mhalt));
    chk("st_next", 32'(state_oh), mhalt ? 32'd8 : 32'd1);
    chk("next_addr", 32'(imem_addr), mpc);
    @(negedge clk);
    chk("wb_pulse", 32'(wb_valid), 32'd0);
  endtask

  function automatic logic [31:0] rand_ins();
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] f3;
    int kind;
    rd = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    f3 = 3'($urandom_range(0, 7));
    kind = int'($urandom_range(0, 9));
    if (kind < 5)
      return {1'b0, 1'($urandom), 5'd0, rs2, rs1, f3, rd, 7'b0110011};
    if (kind < 9)
      return {12'($urandom), rs1, f3, rd, 7'b0010011};
    return {25'($urandom), 7'b0110111};
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) mx[i] = '0;

    @(negedge clk);
    chk("rst_state", 32'(state_oh), 32'd1);
    chk("rst_req", 32'(imem_req), 32'd1);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_instret", 32'(instret), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_wbv", 32'(wb_valid), 32'd0);
    chk("rst_wbrd", 32'(wb_rd), 32'd0);
    chk("rst_wbdata", wb_data, 32'd0);
    chk("small_rst_addr", 32'(addr2), 32'd3);
    @(negedge clk);
    resetn = 1'b1;

    ack2 = 1'b1;
    rdata2 = 32'h0000_0013;
    @(negedge clk);
    ack2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("small_wrap_addr", 32'(addr2), 32'd0);
    chk("small_instret", 32'(inst2), 32'd1);
    chk("small_state", 32'(so2), 32'd1);
    chk("small_wbv", 32'(wbv2), 32'd0);

    run(32'h0050_0093, 0);
    chk("addi_x1", last_wb, 32'd5);
    run(32'h0010_8133, 0);
    chk("add_x2", last_wb, 32'd10);
    run(32'h4020_01B3, 0);
    chk("sub_x3", last_wb, 32'hFFFF_FFF6);
    run(32'h4011_D213, 0);
    chk("srai_x4", last_wb, 32'hFFFF_FFFB);
    run(32'h0030_32B3, 0);
    chk("sltu_x5", last_wb, 32'd1);
    run(32'h0070_0013, 0);
    run(32'h0000_0333, 0);
    chk("add_x6", last_wb, 32'd0);
    run(32'hFFD0_0393, 0);
    run(32'h0010_8133, 4);
    chk("wait_add", last_wb, 32'd10);

    for (int k = 0; k < 60; k++) begin
      run(rand_ins(), int'($urandom_range(0, 3)));
    end

    run(32'h0010_0073, 0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("halt_state", 32'(state_oh), 32'd8);
      chk("halt_req", 32'(imem_req), 32'd0);
      chk("halt_addr", 32'(imem_addr), mpc);
    end

    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    mpc = 0;
    mret = 0;
    mhalt = 1'b0;
    chk("rearm_state", 32'(state_oh), 32'd1);
    chk("rearm_halted", 32'(halted), 32'd0);
    imem_ack = 1'b1;
    imem_rdata = 32'h0630_0093;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    chk("abort_exec", 32'(state_oh), 32'd4);
    resetn = 1'b0;
    #1;
    chk("abort_state", 32'(state_oh), 32'd1);
    chk("abort_instret", 32'(instret), 32'd0);
    @(negedge clk);
    chk("abort_wbv", 32'(wb_valid), 32'd0);
    chk("abort_addr", 32'(imem_addr), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_wbv", 32'(wb_valid), 32'd0);
    chk("post_state", 32'(state_oh), 32'd1);
    chk("post_instret", 32'(instret), 32'd0);
    run(32'h0000_83B3, 0);
    chk("x1_kept", last_wb, mx[1]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_alu_core.md
Name: rv_alu_core

Overview:
- Parametrised multicycle RV32I integer core covering the ALU subset: R-type and I-type ALU ops, with EBREAK/ECALL as halt.
- Fetches instruction words over a req/ack port and owns a 32-entry register bank.
- Exposes a per-instruction writeback strobe, a retire counter and a one-hot state vector for LEDs and debug.
- Sits between the board clock/reset conditioning and a small instruction ROM or BRAM.

Parameters:
- PC_W, 6, width of the word-addressed PC and imem_addr; the PC wraps modulo 2^PC_W.
- RESET_PC, 0, PC value loaded on reset (word address).
- CNT_W, 16, width of the instret retire counter.

Ports:
- clk  in  1  core clock; all state changes on its rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- imem_req  out  1  fetch request; high only in state FETCH.
- imem_addr  out  PC_W  word address of the fetch; equals PC.
- imem_ack  in  1  fetch complete; imem_rdata is valid on this cycle.
- imem_rdata  in  32  instruction word.
- wb_valid  out  1  one-cycle pulse when a register write commits.
- wb_rd  out  5  destination register of the committed write.
- wb_data  out  32  value written.
- instret  out  CNT_W  retired-instruction count; wraps at 2^CNT_W.
- halted  out  1  high once a SYSTEM opcode has executed.
- state_oh  out  4  one-hot state: bit0 FETCH, bit1 REGS, bit2 EXEC, bit3 HALT.

Behaviour:
- Asynchronous reset while resetn=0 sets:
  - PC=RESET_PC, state=FETCH, instr=0, instret=0, halted=0;
  - wb_valid=0, wb_rd=0, wb_data=0;
  - imem_req=1 (it follows the state), state_oh=4'b0001.
- The register bank is not reset. x0 always reads 0, and writes to x0 are discarded.
- FETCH:
  - imem_req=1, imem_addr=PC.
  - On a cycle with imem_ack=1: latch instr<=imem_rdata, go to REGS.
  - Otherwise hold, for unbounded wait states.
  - imem_ack is ignored outside FETCH.
- REGS: rs1<=RF[instr[19:15]], rs2<=RF[instr[24:20]], go to EXEC. Always one cycle.
- EXEC: always one cycle.
  - Opcode 0110011 (R) or 0010011 (I): compute the ALU result.
    - If rd!=0: write RF[rd]; wb_valid=1 on the next cycle with wb_rd/wb_data.
    - PC<=PC+1, instret+=1, go to FETCH.
  - Opcode 1110011: halted<=1, instret+=1, go to HALT. PC is unchanged.
  - Any other opcode: no write, PC<=PC+1, instret+=1, go to FETCH (NOP).
- HALT: absorbing state; only reset leaves it. imem_req=0.
- ALU operands: op1=rs1. op2 is either rs2 (R-type) or the I-type immediate, sign-extended from instr[31:20].
- ALU ops by funct3:
  - 000: ADD. SUB only if R-type and instr[30]=1; I-type 000 is always ADD.
  - 001: SLL, shift amount op2[4:0].
  - 010: SLT, signed compare, result 0 or 1.
  - 011: SLTU, unsigned compare, result 0 or 1.
  - 100: XOR.
  - 101: SRL when instr[30]=0, SRA when instr[30]=1 (both R- and I-type); shift amount op2[4:0].
  - 110: OR.
  - 111: AND.
  - All arithmetic is modulo 2^32; no overflow flags.
- Latency: 3 cycles per instruction with zero-wait ack (ack in the first FETCH cycle), 3+N with N wait cycles.
- wb_valid is exactly one cycle wide, asserted in the FETCH cycle following EXEC. wb_rd/wb_data hold their last values otherwise.
- PC at 2^PC_W-1 increments to 0.
- Reset asserted mid-instruction (any state, including an ack cycle) aborts the instruction: no RF write, no wb_valid, instret not incremented.

Test Plan:
- Reset, then program 0x00500093 (ADDI x1,x0,5), 0x00108133 (ADD x2,x1,x1), ack in the same cycle as req -> wb pulses (1,5) at cycle 3 and (2,10) at cycle 6 after the first FETCH; instret=2.
- Continue with 0x402001B3 (SUB x3,x0,x2), 0x4011D213 (SRAI x4,x3,1), 0x003032B3 (SLTU x5,x0,x3) -> x3=0xFFFFFFF6, x4=0xFFFFFFFB, x5=1.
- 0x00700013 (ADDI x0,x0,7) followed by ADD x6,x0,x0 -> no wb_valid for the first instruction; x6=0; instret still increments.
- Insert 4 wait cycles before imem_ack on one fetch -> the instruction takes 7 cycles, imem_addr is stable throughout, and the result is unchanged.
- 0x00100073 (EBREAK) -> halted=1, state_oh=4'b1000, imem_req=0 for 20+ cycles; PC stays at the EBREAK address.
- PC_W=2 with RESET_PC=3 runs a NOP at address 3 -> the next imem_addr=0.
- Drop resetn during EXEC of an ADDI -> no write and no wb_valid; after release: state_oh=0001, imem_addr=RESET_PC, instret=0.
